// File: rtl/switch_box_config_loader.sv
// -----------------------------------------------------------------------------
// switch_box_config_loader
//
// Writer side of a switch box configuration port. It accepts a word-serial
// bitstream over a valid/ready handshake and builds a shadow copy of the
// configuration. A trailing XOR checksum word is then compared against that
// copy. On a match, the shadow is committed atomically onto config_out.
// A failed or aborted load leaves config_out untouched.
//
// Parameters
//   CONFIG_WIDTH : committed configuration width (multiple of WORD_WIDTH)
//   WORD_WIDTH   : bitstream word width
//
// Ports
//   clock      in   single clock, rising edge
//   nreset     in   asynchronous active-low reset
//   start      in   begin (or restart) a load
//   data_in    in   bitstream word
//   data_valid in   data_in is valid
//   data_ready out  loader accepts a word this cycle (combinational)
//   config_out out  committed configuration, drives switch box config_in
//   busy       out  load in progress
//   done       out  one-cycle pulse after a successful commit
//   error      out  last load failed its checksum; sticky until start/reset
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no load in progress; words are not accepted
// LOAD  | collecting configuration words 0..NUM_WORDS-1 into the shadow
// CHECK | waiting for the checksum word; commit or flag error on transfer
// -----------------------------------------------------------------------------
module switch_box_config_loader #(
    parameter int CONFIG_WIDTH = 160,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    start,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if ((CONFIG_WIDTH % WORD_WIDTH) != 0) begin : g_bad_width
        $error("CONFIG_WIDTH (%0d) must be a multiple of WORD_WIDTH (%0d)",
               CONFIG_WIDTH, WORD_WIDTH);
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        word_cnt;
    logic [WORD_WIDTH-1:0]   acc;
    logic [CONFIG_WIDTH-1:0] shadow;
    logic                    xfer;

    // start takes priority over any word presented in the same cycle.
    assign data_ready = (state != IDLE) && !start;
    assign xfer       = data_valid && data_ready;

    // The shadow is deliberately left out of reset. Every slice is rewritten
    // before the CHECK state can commit it, so stale content never reaches
    // config_out.
    always_ff @(posedge clock) begin
        if (xfer && (state == LOAD)) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (word_cnt == CNT_W'(k)) begin
                    shadow[k*WORD_WIDTH +: WORD_WIDTH] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            word_cnt   <= '0;
            acc        <= '0;
            config_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state    <= LOAD;
                busy     <= 1'b1;
                word_cnt <= '0;
                acc      <= '0;
                error    <= 1'b0;
            end else if (xfer) begin
                case (state)
                    LOAD: begin
                        acc <= acc ^ data_in;
                        // The counter stops at the last index instead of
                        // wrapping; CHECK then consumes the checksum word.
                        if (word_cnt == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            word_cnt <= word_cnt + CNT_ONE;
                        end
                    end
                    CHECK: begin
                        if (data_in == acc) begin
                            config_out <= shadow;
                            done       <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/switch_box_config_loader.md
# switch_box_config_loader

Writer side of the switch box configuration port: accepts a word-serial bitstream over a valid/ready handshake, assembles it into a shadow register, verifies an XOR checksum, and atomically commits the result onto the switch box's `config_in` bus. It sits between the tile-level configuration controller and one switch box. A rejected or aborted load never disturbs the active configuration.

## Interface
- `CONFIG_WIDTH`, 160, width of the committed configuration bus. Must be a multiple of `WORD_WIDTH`; any other value is an elaboration error.
- `WORD_WIDTH`, 8, bitstream word width.
- `NUM_WORDS`, derived as `CONFIG_WIDTH/WORD_WIDTH` (20 with the defaults).
- `clock` in 1: the single clock; all state changes on its rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new load; aborts any load in progress.
- `data_in` in `WORD_WIDTH`: bitstream word.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: the loader accepts a word this cycle.
- `config_out` out `CONFIG_WIDTH`: committed configuration, connected to the switch box `config_in`.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse on a successful commit.
- `error` out 1: the last load failed its checksum. Sticky until the next `start` or reset.

## Operation
- States: IDLE, LOAD, CHECK.
- Handshake: a transfer occurs when `data_valid && data_ready`.
  - `data_ready = (state != IDLE) && !start`, combinational.
  - `data_in` is ignored when no transfer occurs.
- IDLE:
  - `start` moves the FSM to LOAD.
  - On that edge, word counter <= 0, checksum accumulator <= 0, `error` <= 0.
- LOAD:
  - Transfer k (k = 0..NUM_WORDS-1) writes `shadow[k*WORD_WIDTH +: WORD_WIDTH]` and does `acc <= acc ^ data_in`.
  - Word 0 lands in bits [7:0], i.e. first in the config bus.
  - The transfer with k = NUM_WORDS-1 moves the FSM to CHECK.
- CHECK: the next transfer is the checksum word.
  - If `data_in == acc`: `config_out <= shadow`, `done` <= 1 for one cycle, go to IDLE.
  - Otherwise: `error` <= 1, `config_out` unchanged, go to IDLE.
- `start` in LOAD or CHECK:
  - Restarts: counter, acc and `error` are cleared; the state becomes or stays LOAD.
  - No word is accepted that cycle.
  - The shadow content is stale but is fully overwritten before any commit.
- `busy` = (state != IDLE).
- Counter width is `$clog2(NUM_WORDS)`. It never wraps: CHECK is entered exactly at NUM_WORDS-1.
- The shadow register is not reset. It is unobservable until it has been fully written.

## Timing
- Reset (async assert, any cycle):
  - `config_out` = 0 (every switch box mux selects input 0).
  - `data_ready` = 0, `busy` = 0, `done` = 0, `error` = 0, state IDLE, counter and acc = 0.
  - Deassertion is sampled at the next `clock` edge.
- `start` sampled high at edge E: `busy` = 1 and `data_ready` = 1 (if `start` is low) from E onward.
- Throughput is one word per cycle. Minimum load is NUM_WORDS+1 = 21 transfer cycles after the `start` cycle.
- Checksum transfer at edge C:
  - `config_out` changes and `done` = 1 in the cycle following C.
  - `done` = 0 again after edge C+1. `busy` = 0 from C.
- `config_out` changes only at a successful-checksum edge or on reset. No partial update is ever visible.
- `error` is set at the failing checksum edge and persists through IDLE.
- `start` in the same cycle as `data_valid` in any state: `start` wins and the word is dropped.
- `data_valid` in IDLE without `start`: ignored, `data_ready` = 0.
- Reset mid-load: immediate return to reset values, including `config_out` = 0.

## Test plan
- Reset: hold `nreset` = 0 with random inputs -> `config_out` = 0, `data_ready`/`busy`/`done`/`error` = 0. Release, idle 5 cycles -> outputs unchanged.
- Good load: `start`, then words 0x00..0x13 back-to-back, then checksum 0x00 -> `config_out[7:0]` = 0x00, `[15:8]` = 0x01, `[159:152]` = 0x13. `done` high exactly one cycle, after the checksum edge. `error` = 0.
- Bad checksum: after the good load, `start`, 20 words of 0xAA, checksum 0x01 (expected 0x00) -> `error` = 1, `done` never pulses, `config_out` still equals the previous load.
- Backpressure/gaps: words 0x00..0x13 with `data_valid` toggling every other cycle, checksum 0x00 -> result identical to the good load. The counter advances only on transfers.
- Abort: `start`, 10 words of 0x55, `start` again with `data_valid` = 1 (word dropped), then 20 words of 0xFF and checksum 0x00 -> `config_out` = all ones, `done` pulses once.
- Reset mid-load: after a committed all-ones config, `start`, 7 words, then pulse `nreset` low -> `config_out` = 0 immediately, `busy` = 0. A subsequent full good load commits normally.
